div_op_sequencer: RTL and testbench

//  Upstream feeder for the multi-cycle signed divider (Start/Num/Den -> Done/Coc/Res).

---
 rtl/div_op_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_div_op_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_op_sequencer.sv
// Buffers operand pairs and issues them one at a time to a multi-cycle signed divider; divide-by-zero is answered
// locally and each divide is bounded by a timeout. in_ready drops only when the FIFO is full; a result is held until out_ready.

module div_op_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_vld_i,
  input  logic [W-1:0]           wr_dat_i,
  input  logic                   rd_rdy_i,
  output logic [W-1:0]           rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign do_wr    = wr_vld_i && !full_o;
  assign do_rd    = rd_rdy_i && !empty_o;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  // Pointers wrap naturally at the power-of-two depth; the count tells full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

module div_op_sequencer #(
  parameter int tamanyo    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2*tamanyo+8
) (
  input  logic                          CLK,
  input  logic                          RSTa,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [tamanyo-1:0]            in_num,
  input  logic [tamanyo-1:0]            in_den,
  output logic                          Start,
  output logic [tamanyo-1:0]            Num,
  output logic [tamanyo-1:0]            Den,
  input  logic                          Done,
  input  logic [tamanyo-1:0]            Coc,
  input  logic [tamanyo-1:0]            Res,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [tamanyo-1:0]            out_coc,
  output logic [tamanyo-1:0]            out_res,
  output logic                          out_dz,
  output logic                          out_tmo,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);

  typedef struct packed {
    logic [tamanyo-1:0] num;
    logic [tamanyo-1:0] den;
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [tamanyo-1:0] num_q, num_d, den_q, den_d;
  logic [tamanyo-1:0] coc_q, coc_d, res_q, res_d;
  logic               dz_q, dz_d, tmo_q, tmo_d, vld_q, vld_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  op_t  wr_op, head;
  logic fifo_full, fifo_empty, pop;

  assign wr_op = '{num: in_num, den: in_den};

  div_op_fifo #(.W($bits(op_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RSTa),
    .wr_vld_i (in_valid),
    .wr_dat_i (wr_op),
    .rd_rdy_i (pop),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Held low while reset is applied so every output reads zero during reset.
  assign in_ready  = !fifo_full && !RSTa;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign Start     = start_q;
  assign Num       = num_q;
  assign Den       = den_q;
  assign out_valid = vld_q;
  assign out_coc   = coc_q;
  assign out_res   = res_q;
  assign out_dz    = dz_q;
  assign out_tmo   = tmo_q;

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      tmo_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      num_q   <= num_d;
      den_q   <= den_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    num_d   = num_q;
    den_d   = den_q;
    coc_d   = coc_q;
    res_d   = res_q;
    dz_d    = dz_q;
    tmo_d   = tmo_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.den == '0) begin
            coc_d   = '1;
            res_d   = head.num;
            dz_d    = 1'b1;
            tmo_d   = 1'b0;
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end else begin
            num_d   = head.num;
            den_d   = head.den;
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Done wins over a timeout landing on the same edge.
        if (Done) begin
          coc_d   = Coc;
          res_d   = Res;
          dz_d    = 1'b0;
          tmo_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          coc_d   = '0;
          res_d   = '0;
          dz_d    = 1'b0;
          tmo_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_div_op_sequencer.sv
// Bench for div_op_sequencer: directed scenarios plus random traffic against a divider model and an
// in-order result queue computed with plain signed arithmetic.

module tb_div_op_sequencer;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 2*W+8;

  typedef struct packed {
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
    logic         tmo;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] n;
    logic [W-1:0] d;
  } op_t;

  logic         CLK = 1'b0;
  logic         RSTa;
  logic         in_valid, in_ready;
  logic [W-1:0] in_num, in_den;
  logic         Start;
  logic [W-1:0] Num, Den;
  logic         Done, model_done, stray_done;
  logic [W-1:0] Coc, Res;
  logic         out_valid, out_ready;
  logic [W-1:0] out_coc, out_res;
  logic         out_dz, out_tmo, busy;
  logic [2:0]   fifo_count;

  exp_t exp_q[$];
  op_t  iss_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   start_cnt = 0;
  bit   mute = 1'b0;
  bit   rand_rdy = 1'b0;

  assign Done = model_done | stray_done;

  always #5 CLK = ~CLK;

  div_op_sequencer #(.tamanyo(W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTa(RSTa),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
    .Start(Start), .Num(Num), .Den(Den), .Done(Done), .Coc(Coc), .Res(Res),
    .out_valid(out_valid), .out_ready(out_ready), .out_coc(out_coc), .out_res(out_res),
    .out_dz(out_dz), .out_tmo(out_tmo), .busy(busy), .fifo_count(fifo_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_result(input logic [W-1:0] n, input logic [W-1:0] d, input bit tmo);
    exp_t r;
    logic signed [W-1:0] sn, sd;
    sn = n;
    sd = d;
    r = '0;
    if (d == '0) begin
      r.coc = '1;
      r.res = n;
      r.dz  = 1'b1;
    end else if (tmo) begin
      r.tmo = 1'b1;
    end else begin
      r.coc = sn / sd;
      r.res = sn % sd;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic gen(output logic [W-1:0] n, output logic [W-1:0] d, input bit allow_zero);
    n = $urandom;
    if ($urandom_range(0, 2) == 0) n = W'($urandom_range(0, 2000)) - W'(1000);
    d = $urandom;
    if ($urandom_range(0, 1) == 0) d = W'($urandom_range(1, 40)) * (($urandom_range(0, 1) == 0) ? W'(1) : '1);
    if (d == '0) d = W'(3);
    if (n == {1'b1, {(W-1){1'b0}}} && d == '1) d = W'(1);
    if (allow_zero && $urandom_range(0, 5) == 0) d = '0;
  endtask

  task automatic push(input logic [W-1:0] n, input logic [W-1:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    while (in_ready !== 1'b1 && g < 300) begin
      tick();
      g++;
    end
    check("push_accept", in_ready, 1);
    if (in_ready === 1'b1) begin
      exp_q.push_back(model_result(n, d, mute));
      if (d != '0) iss_q.push_back('{n: n, d: d});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int g = 0;
    while (out_valid !== 1'b1 && g < 300) begin
      tick();
      g++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic drain();
    int g = 0;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy !== 1'b0) && g < 2000) begin
      tick();
      g++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // Divider model: answers each Start after a random delay unless muted.
  logic [W-1:0] mn, md;
  op_t          mo;
  int           lat;
  initial begin
    model_done = 1'b0;
    Coc = '0;
    Res = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (Start === 1'b1) begin
        mn = Num;
        md = Den;
        start_cnt++;
        if (iss_q.size() == 0) begin
          check("start_unexpected", Start, 0);
        end else begin
          mo = iss_q.pop_front();
          check("start_num", mn, mo.n);
          check("start_den", md, mo.d);
        end
        @(posedge CLK);
        #1;
        check("start_pulse", Start, 0);
        if (!mute) begin
          lat = $urandom_range(0, 6);
          repeat (lat) begin
            @(posedge CLK);
            #1;
          end
          check("num_stable", Num, mn);
          check("den_stable", Den, md);
          model_done = 1'b1;
          Coc = $signed(mn) / $signed(md);
          Res = $signed(mn) % $signed(md);
          @(posedge CLK);
          #1;
          model_done = 1'b0;
          check("done_to_valid", out_valid, 1);
        end
      end
    end
  end

  // Result monitor: every accepted result must match the head of the expected queue.
  exp_t me;
  initial begin
    forever begin
      @(negedge CLK);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 0);
        end else if (out_ready === 1'b1) begin
          me = exp_q.pop_front();
          check("res_coc", out_coc, me.coc);
          check("res_res", out_res, me.res);
          check("res_dz", out_dz, me.dz);
          check("res_tmo", out_tmo, me.tmo);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] rn, rd;
  exp_t         held;
  int           sc;
  initial begin
    RSTa = 1'b1; in_valid = 1'b0; in_num = '0; in_den = '0;
    out_ready = 1'b0; stray_done = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_start", Start, 0);
    check("rst_busy", busy, 0);
    tick(); tick();
    RSTa = 1'b0;
    tick();
    check("rel_in_ready", in_ready, 1);
    check("rel_count", fifo_count, 0);
    check("rel_out_coc", out_coc, 0);

    // 100/7 with latency from acceptance to Start.
    out_ready = 1'b1;
    push(100, 7);
    check("t1_count", fifo_count, 1);
    check("t1_busy", busy, 1);
    check("t1_no_start_yet", Start, 0);
    tick();
    check("t1_start", Start, 1);
    check("t1_num", Num, 100);
    check("t1_den", Den, 7);
    check("t1_popped", fifo_count, 0);
    wait_valid("t1_valid");
    check("t1_coc", out_coc, 14);
    check("t1_res", out_res, 2);
    check("t1_dz", out_dz, 0);
    check("t1_tmo", out_tmo, 0);
    tick();
    check("t1_released", out_valid, 0);

    // -55/0 handled locally one cycle after the pop.
    sc = start_cnt;
    push(-55, 0);
    tick();
    check("t2_valid", out_valid, 1);
    check("t2_coc", out_coc, 32'hFFFF_FFFF);
    check("t2_res", out_res, 32'hFFFF_FFC9);
    check("t2_dz", out_dz, 1);
    check("t2_tmo", out_tmo, 0);
    repeat (3) tick();
    check("t2_no_start", start_cnt, sc);

    // Six back-to-back pushes with the consumer stalled: FIFO plus one in flight.
    out_ready = 1'b0;
    sc = start_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gen(rn, rd, 1'b0);
      in_num = rn;
      in_den = rd;
      check("t3_in_ready", in_ready, (i < 5) ? 1 : 0);
      if (in_ready === 1'b1) begin
        exp_q.push_back(model_result(rn, rd, mute));
        iss_q.push_back('{n: rn, d: rd});
      end
      tick();
    end
    in_valid = 1'b0;
    check("t3_full_count", fifo_count, 4);
    drain();
    check("t3_starts", start_cnt - sc, 5);

    // Stalled HOLD keeps the result and the FIFO untouched.
    out_ready = 1'b0;
    gen(rn, rd, 1'b0);
    push(rn, rd);
    wait_valid("t4_valid");
    held = exp_q[0];
    gen(rn, rd, 1'b1);
    push(rn, rd);
    gen(rn, rd, 1'b0);
    push(rn, rd);
    sc = start_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_coc", out_coc, held.coc);
      check("t4_hold_res", out_res, held.res);
      check("t4_hold_count", fifo_count, 2);
    end
    check("t4_no_start", start_cnt, sc);
    drain();

    // Divider silent: timeout after TMO wait cycles, late Done ignored.
    mute = 1'b1;
    out_ready = 1'b0;
    gen(rn, rd, 1'b0);
    push(rn, rd);
    tick();
    check("t5_start", Start, 1);
    repeat (TMO) tick();
    check("t5_not_yet", out_valid, 0);
    tick();
    check("t5_valid", out_valid, 1);
    check("t5_tmo", out_tmo, 1);
    check("t5_coc", out_coc, 0);
    check("t5_res", out_res, 0);
    check("t5_dz", out_dz, 0);
    sc = start_cnt;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    check("t5_late_done_tmo", out_tmo, 1);
    check("t5_late_done_coc", out_coc, 0);
    check("t5_late_done_start", start_cnt, sc);
    mute = 1'b0;
    out_ready = 1'b1;
    gen(rn, rd, 1'b0);
    push(rn, rd);
    drain();

    // Reset during WAIT with another op buffered.
    mute = 1'b1;
    out_ready = 1'b1;
    gen(rn, rd, 1'b0);
    push(rn, rd);
    gen(rn, rd, 1'b0);
    push(rn, rd);
    tick(); tick();
    check("t6_pre_busy", busy, 1);
    RSTa = 1'b1;
    exp_q.delete();
    iss_q.delete();
    #1;
    check("t6_rst_start", Start, 0);
    check("t6_rst_num", Num, 0);
    check("t6_rst_den", Den, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_coc", out_coc, 0);
    check("t6_rst_res", out_res, 0);
    check("t6_rst_flags", {out_dz, out_tmo}, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_in_ready", in_ready, 0);
    tick();
    RSTa = 1'b0;
    tick();
    check("t6_rel_in_ready", in_ready, 1);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stray_valid", out_valid, 0);
      check("t6_stray_busy", busy, 0);
    end
    mute = 1'b0;
    gen(rn, rd, 1'b0);
    push(rn, rd);
    drain();

    // Random traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      gen(rn, rd, 1'b1);
      push(rn, rd);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
